// File: rtl/sample_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_sched_pkg
// Description : Shared state encoding and counter constants for sample_scheduler.
// Revision    : 1.0
// ============================================================================
package sample_sched_pkg;

    localparam int c_STATE_WIDTH = 2;

    localparam logic [c_STATE_WIDTH-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_STATE_WIDTH-1:0] c_ST_ARM  = 2'd1;
    localparam logic [c_STATE_WIDTH-1:0] c_ST_BUSY = 2'd2;

    typedef enum logic [c_STATE_WIDTH-1:0] {
        IDLE = c_ST_IDLE,
        ARM  = c_ST_ARM,
        BUSY = c_ST_BUSY
    } sched_state_t;

    localparam int c_COUNT_WIDTH = 16;

    // Counters take the low WIDTH bits of this as their saturation value.
    localparam int                           c_COUNT_MAX_WIDTH = 64;
    localparam logic [c_COUNT_MAX_WIDTH-1:0] c_COUNT_SAT       = '1;

endpackage : sample_sched_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; synchronous active-high reset.
// Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    import sample_sched_pkg::*;

    localparam logic [WIDTH-1:0] c_SAT = c_COUNT_SAT[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != c_SAT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sample_scheduler
// Description : Starts the DSP engine once per I2S frame, collects its result,
//               and handles muting, overrun counting and an engine watchdog.
// Revision    : 1.0
// ============================================================================
module sample_scheduler
    import sample_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int MUTE_SAMPLES   = 64,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int COUNT_WIDTH    = c_COUNT_WIDTH
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     rx_valid,
    input  logic [DATA_WIDTH-1:0]    rx_sample,
    input  logic                     engine_ready,
    input  logic [DATA_WIDTH-1:0]    engine_out,
    output logic                     tick,
    output logic [DATA_WIDTH-1:0]    engine_in,
    output logic [DATA_WIDTH-1:0]    tx_sample,
    output logic                     frame_done,
    output logic                     overrun,
    output logic [COUNT_WIDTH-1:0]   overrun_count,
    output logic [COUNT_WIDTH-1:0]   timeout_count,
    output logic [c_STATE_WIDTH-1:0] state
);

    localparam int                      c_WD_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_WIDTH-1:0]   c_WD_LAST    = c_WD_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam int                      c_MUTE_WIDTH = (MUTE_SAMPLES > 0) ? $clog2(MUTE_SAMPLES + 1) : 1;
    localparam logic [c_MUTE_WIDTH-1:0] c_MUTE_LOAD  = c_MUTE_WIDTH'(MUTE_SAMPLES);

    sched_state_t            r_state;
    logic                    r_rx_valid_q;
    logic                    r_tick;
    logic [DATA_WIDTH-1:0]   r_engine_in;
    logic [DATA_WIDTH-1:0]   r_tx_sample;
    logic                    r_frame_done;
    logic                    r_overrun;
    logic [c_MUTE_WIDTH-1:0] r_mute;
    logic [c_WD_WIDTH-1:0]   r_wd;

    sched_state_t            w_state_nxt;
    logic                    w_new_frame;
    logic                    w_tick_nxt;
    logic [DATA_WIDTH-1:0]   w_engine_in_nxt;
    logic [DATA_WIDTH-1:0]   w_tx_sample_nxt;
    logic                    w_frame_done_nxt;
    logic                    w_overrun_nxt;
    logic                    w_timeout_inc;
    logic [c_MUTE_WIDTH-1:0] w_mute_nxt;
    logic [c_WD_WIDTH-1:0]   w_wd_nxt;

    assign w_new_frame = rx_valid & ~r_rx_valid_q;

    always_comb begin
        w_state_nxt      = r_state;
        w_tick_nxt       = 1'b0;
        w_engine_in_nxt  = r_engine_in;
        w_tx_sample_nxt  = r_tx_sample;
        w_frame_done_nxt = 1'b0;
        w_overrun_nxt    = 1'b0;
        w_timeout_inc    = 1'b0;
        w_mute_nxt       = r_mute;
        w_wd_nxt         = r_wd;

        case (r_state)
            IDLE: begin
                if (w_new_frame && enable) begin
                    w_engine_in_nxt = rx_sample;
                    w_tick_nxt      = 1'b1;
                    w_state_nxt     = ARM;
                end
            end
            // Engine still shows ready here; its busy indication lags tick by a cycle.
            ARM: begin
                w_overrun_nxt = w_new_frame;
                w_wd_nxt      = '0;
                w_state_nxt   = BUSY;
            end
            BUSY: begin
                w_overrun_nxt = w_new_frame;
                w_wd_nxt      = r_wd + 1'b1;
                if (engine_ready) begin
                    w_tx_sample_nxt  = (r_mute != '0) ? '0 : engine_out;
                    w_frame_done_nxt = 1'b1;
                    if (r_mute != '0) begin
                        w_mute_nxt = r_mute - 1'b1;
                    end
                    w_state_nxt = IDLE;
                end else if (r_wd == c_WD_LAST) begin
                    w_timeout_inc = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Holding the reload while disabled restarts the mute window at enable rise.
        if (!enable) begin
            w_mute_nxt = c_MUTE_LOAD;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rx_valid_q <= 1'b0;
            r_tick       <= 1'b0;
            r_engine_in  <= '0;
            r_tx_sample  <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_mute       <= c_MUTE_LOAD;
            r_wd         <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rx_valid_q <= rx_valid;
            r_tick       <= w_tick_nxt;
            r_engine_in  <= w_engine_in_nxt;
            r_tx_sample  <= w_tx_sample_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_overrun    <= w_overrun_nxt;
            r_mute       <= w_mute_nxt;
            r_wd         <= w_wd_nxt;
        end
    end

    sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_overrun_cnt (
        .clk   (sys_clk),
        .rst   (reset),
        .inc   (w_overrun_nxt),
        .count (overrun_count)
    );

    sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_timeout_cnt (
        .clk   (sys_clk),
        .rst   (reset),
        .inc   (w_timeout_inc),
        .count (timeout_count)
    );

    assign tick       = r_tick;
    assign engine_in  = r_engine_in;
    assign tx_sample  = r_tx_sample;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign state      = r_state;

endmodule : sample_scheduler
`default_nettype wire

// File: tb/tb_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_scheduler
// Description : Self-checking bench: directed vectors plus random traffic vs a frame-level model.
// Revision    : 1.0
// ============================================================================
module tb_sample_scheduler;

    localparam int DW   = 16;
    localparam int MUTE = 2;
    localparam int TO   = 16;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          sys_clk = 1'b0;
    logic          reset, enable, rx_valid, engine_ready;
    logic [DW-1:0] rx_sample, engine_out;
    logic          tick, frame_done, overrun;
    logic [DW-1:0] engine_in, tx_sample;
    logic [CW-1:0] overrun_count, timeout_count;
    logic [1:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    sample_scheduler #(
        .DATA_WIDTH     (DW),
        .MUTE_SAMPLES   (MUTE),
        .TIMEOUT_CYCLES (TO),
        .COUNT_WIDTH    (CW)
    ) dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .enable        (enable),
        .rx_valid      (rx_valid),
        .rx_sample     (rx_sample),
        .engine_ready  (engine_ready),
        .engine_out    (engine_out),
        .tick          (tick),
        .engine_in     (engine_in),
        .tx_sample     (tx_sample),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .overrun_count (overrun_count),
        .timeout_count (timeout_count),
        .state         (state)
    );

    // Frame-level reference: phase 0 waiting, 1 starting, 2 engine running.
    bit          m_prev_rv;
    int          m_phase, m_busy, m_oc, m_tc, m_mute;
    bit          m_tick, m_done, m_ovr;
    logic [15:0] m_ein, m_tx;

    task automatic model_step();
        bit fr;
        if (reset) begin
            m_prev_rv = 0; m_phase = 0; m_busy = 0; m_tick = 0; m_done = 0; m_ovr = 0;
            m_ein = '0; m_tx = '0; m_oc = 0; m_tc = 0; m_mute = MUTE;
            return;
        end
        fr = rx_valid && !m_prev_rv;
        m_prev_rv = rx_valid;
        m_tick = 0; m_done = 0; m_ovr = 0;
        if (m_phase != 0 && fr) begin
            m_ovr = 1;
            if (m_oc < CMAX) m_oc++;
        end
        if (m_phase == 0) begin
            if (fr && enable) begin
                m_ein = rx_sample; m_tick = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2; m_busy = 0;
        end else begin
            m_busy++;
            if (engine_ready) begin
                m_tx = (m_mute > 0) ? 16'h0 : engine_out;
                m_done = 1;
                if (m_mute > 0) m_mute--;
                m_phase = 0;
            end else if (m_busy == TO) begin
                if (m_tc < CMAX) m_tc++;
                m_phase = 0;
            end
        end
        if (!enable) m_mute = MUTE;
    endtask

    task automatic check_model(input string name);
        n_tests++;
        if (tick !== m_tick || state !== 2'(m_phase) || engine_in !== m_ein || tx_sample !== m_tx ||
            frame_done !== m_done || overrun !== m_ovr || overrun_count !== 4'(m_oc) ||
            timeout_count !== 4'(m_tc)) begin
            n_fail++;
            $display("FAIL %s t=%0t: dut tick=%0b st=%0d ein=%h tx=%h done=%0b ovr=%0b oc=%0d tc=%0d | want tick=%0b st=%0d ein=%h tx=%h done=%0b ovr=%0b oc=%0d tc=%0d",
                     name, $time, tick, state, engine_in, tx_sample, frame_done, overrun, overrun_count,
                     timeout_count, m_tick, m_phase, m_ein, m_tx, m_done, m_ovr, m_oc, m_tc);
        end
    endtask

    task automatic cycle(input string name);
        @(posedge sys_clk);
        #1;
        model_step();
        check_model(name);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic run_frame(input logic [15:0] s, input logic [15:0] r, input int lat,
                             output int ticks, output int dones);
        ticks = 0; dones = 0;
        rx_sample = s; rx_valid = 1'b1;
        for (int c = 0; c < lat + 8; c++) begin
            cycle("frame");
            if (tick === 1'b1) ticks++;
            if (frame_done === 1'b1) dones++;
            if (c == 0) engine_ready = 1'b0;
            if (c == 2) rx_valid = 1'b0;
            if (c == lat) begin
                engine_ready = 1'b1; engine_out = r;
            end
        end
    endtask

    typedef struct {
        logic rv; logic [15:0] rs; logic rdy; logic [15:0] eo;
        logic tk; logic [1:0] st; logic [15:0] ein; logic [15:0] tx;
        logic dn; logic ov; logic [3:0] oc; logic [3:0] tc;
    } vec_t;

    function automatic vec_t mk(input bit rv, input int rs, input bit rdy, input int eo,
                                input bit tk, input int st, input int ein, input int tx,
                                input bit dn, input bit ov, input int oc, input int tc);
        vec_t v;
        v.rv = rv; v.rs = 16'(rs); v.rdy = rdy; v.eo = 16'(eo);
        v.tk = tk; v.st = 2'(st); v.ein = 16'(ein); v.tx = 16'(tx);
        v.dn = dn; v.ov = ov; v.oc = 4'(oc); v.tc = 4'(tc);
        return v;
    endfunction

    initial begin
        vec_t vecs[19];
        int   ticks, dones, ovrs, busy, eng_lat, rv_left;
        bit   reached, rv_hi;
        logic [15:0] mute_exp[3];

        reset = 1'b1; enable = 1'b1; rx_valid = 1'b0; rx_sample = '0;
        engine_ready = 1'b1; engine_out = '0;
        cycle("reset"); cycle("reset");
        chk("reset_state", {31'd0, state == 2'd0}, 32'd1);
        chk("reset_outs", {tick, frame_done, overrun, engine_in, tx_sample, overrun_count, timeout_count}, 32'd0);
        reset = 1'b0;
        cycle("idle");

        // Mute window: the first MUTE completed frames are forced to zero.
        mute_exp[0] = 16'h0000; mute_exp[1] = 16'h0000; mute_exp[2] = 16'h7FFF;
        for (int f = 0; f < 3; f++) begin
            run_frame(16'(16'h0011 * (f + 1)), 16'h7FFF, 4, ticks, dones);
            chk("mute_tx", tx_sample, mute_exp[f]);
            chk("mute_ticks", ticks, 1);
            chk("mute_dones", dones, 1);
        end

        // Basic frame with an overrun while busy, then a completion-cycle collision.
        vecs[0]  = mk(1, 'h1234, 1, 'h0000, 1, 1, 'h1234, 'h7FFF, 0, 0, 0, 0);
        vecs[1]  = mk(1, 'h1234, 0, 'h0000, 0, 2, 'h1234, 'h7FFF, 0, 0, 0, 0);
        vecs[2]  = mk(1, 'h1234, 0, 'h0000, 0, 2, 'h1234, 'h7FFF, 0, 0, 0, 0);
        vecs[3]  = mk(0, 'h1234, 0, 'h0000, 0, 2, 'h1234, 'h7FFF, 0, 0, 0, 0);
        vecs[4]  = mk(1, 'h5555, 0, 'h0000, 0, 2, 'h1234, 'h7FFF, 0, 1, 1, 0);
        vecs[5]  = mk(0, 'h5555, 0, 'h0000, 0, 2, 'h1234, 'h7FFF, 0, 0, 1, 0);
        for (int i = 6; i <= 10; i++)
            vecs[i] = mk(0, 'h5555, 0, 'h0000, 0, 2, 'h1234, 'h7FFF, 0, 0, 1, 0);
        vecs[11] = mk(0, 'h5555, 1, 'h0ABC, 0, 0, 'h1234, 'h0ABC, 1, 0, 1, 0);
        vecs[12] = mk(0, 'h5555, 1, 'h0ABC, 0, 0, 'h1234, 'h0ABC, 0, 0, 1, 0);
        vecs[13] = mk(1, 'h2468, 1, 'h0ABC, 1, 1, 'h2468, 'h0ABC, 0, 0, 1, 0);
        vecs[14] = mk(0, 'h2468, 0, 'h0ABC, 0, 2, 'h2468, 'h0ABC, 0, 0, 1, 0);
        vecs[15] = mk(0, 'h2468, 0, 'h0ABC, 0, 2, 'h2468, 'h0ABC, 0, 0, 1, 0);
        vecs[16] = mk(1, 'h1357, 1, 'h0BEE, 0, 0, 'h2468, 'h0BEE, 1, 1, 2, 0);
        vecs[17] = mk(1, 'h1357, 1, 'h0BEE, 0, 0, 'h2468, 'h0BEE, 0, 0, 2, 0);
        vecs[18] = mk(0, 'h1357, 1, 'h0BEE, 0, 0, 'h2468, 'h0BEE, 0, 0, 2, 0);
        for (int i = 0; i < 19; i++) begin
            rx_valid = vecs[i].rv; rx_sample = vecs[i].rs;
            engine_ready = vecs[i].rdy; engine_out = vecs[i].eo;
            cycle("table_model");
            n_tests++;
            if ({tick, state, engine_in, tx_sample, frame_done, overrun, overrun_count, timeout_count} !==
                {vecs[i].tk, vecs[i].st, vecs[i].ein, vecs[i].tx, vecs[i].dn, vecs[i].ov, vecs[i].oc, vecs[i].tc}) begin
                n_fail++;
                $display("FAIL table row %0d: got tick=%0b st=%0d ein=%h tx=%h done=%0b ovr=%0b oc=%0d tc=%0d, expected tick=%0b st=%0d ein=%h tx=%h done=%0b ovr=%0b oc=%0d tc=%0d",
                         i, tick, state, engine_in, tx_sample, frame_done, overrun, overrun_count, timeout_count,
                         vecs[i].tk, vecs[i].st, vecs[i].ein, vecs[i].tx, vecs[i].dn, vecs[i].ov, vecs[i].oc, vecs[i].tc);
            end
        end

        // Watchdog: engine never answers.
        rx_sample = 16'hBEEF; rx_valid = 1'b1;
        cycle("wdog_start");
        chk("wdog_tick", tick, 1);
        rx_valid = 1'b0; engine_ready = 1'b0;
        busy = 0; dones = 0; reached = 0;
        for (int c = 0; c < 100; c++) begin
            cycle("wdog");
            if (frame_done === 1'b1) dones++;
            if (state === 2'd2) busy++;
            if (state === 2'd0) begin
                reached = 1;
                break;
            end
        end
        chk("wdog_reached_idle", reached, 1);
        chk("wdog_busy_cycles", busy, TO);
        chk("wdog_timeout_count", timeout_count, 1);
        chk("wdog_tx_held", tx_sample, 16'h0BEE);
        chk("wdog_no_done", dones, 0);
        run_frame(16'h4242, 16'h1111, 6, ticks, dones);
        chk("after_wdog_tx", tx_sample, 16'h1111);
        chk("after_wdog_done", dones, 1);

        // Reset while the engine is running.
        rx_sample = 16'h7777; rx_valid = 1'b1;
        cycle("rst_busy");
        rx_valid = 1'b0; engine_ready = 1'b0;
        cycle("rst_busy"); cycle("rst_busy");
        chk("rst_in_busy_state", state, 2);
        reset = 1'b1;
        cycle("rst_busy");
        chk("rst_state_idle", state, 0);
        chk("rst_outs_zero", {tick, frame_done, overrun, engine_in, tx_sample, overrun_count, timeout_count}, 32'd0);
        reset = 1'b0;
        cycle("rst_after");
        chk("rst_tick_low", tick, 0);
        chk("rst_idle_after", state, 0);
        engine_ready = 1'b1;

        // Disable: edges ignored, and the mute window restarts on enable rise.
        run_frame(16'h0101, 16'h2222, 3, ticks, dones);
        run_frame(16'h0202, 16'h2222, 3, ticks, dones);
        enable = 1'b0;
        ticks = 0; ovrs = 0;
        for (int e = 0; e < 5; e++) begin
            rx_valid = 1'b1; rx_sample = 16'(e);
            for (int k = 0; k < 4; k++) begin
                cycle("disabled");
                if (tick === 1'b1) ticks++;
                if (overrun === 1'b1) ovrs++;
                if (k == 1) rx_valid = 1'b0;
            end
        end
        chk("disabled_ticks", ticks, 0);
        chk("disabled_overruns", ovrs, 0);
        enable = 1'b1;
        run_frame(16'h3333, 16'h6666, 5, ticks, dones);
        chk("remute_tx", tx_sample, 16'h0000);
        chk("remute_done", dones, 1);

        // Overrun counter saturation: edges every other cycle, engine silent.
        engine_ready = 1'b0;
        for (int c = 0; c < 70; c++) begin
            rx_valid = (c % 2 == 0);
            rx_sample = 16'(c);
            cycle("saturate");
        end
        rx_valid = 1'b0;
        chk("overrun_saturated", overrun_count, CMAX);
        engine_ready = 1'b1;
        cycle("saturate");

        // Random traffic against the model.
        eng_lat = 0; rv_left = 5; rv_hi = 0;
        for (int c = 0; c < 3000; c++) begin
            cycle("random");
            if (tick === 1'b1) begin
                engine_ready = 1'b0;
                eng_lat = int'($urandom_range(1, 20));
            end else if (eng_lat > 0) begin
                eng_lat--;
                if (eng_lat == 0) begin
                    engine_ready = 1'b1;
                    engine_out = 16'($urandom);
                end
            end
            rv_left--;
            if (rv_left <= 0) begin
                if (rv_hi) begin
                    rx_valid = 1'b0;
                    rv_left = int'($urandom_range(1, 30));
                end else begin
                    rx_valid = 1'b1;
                    rx_sample = 16'($urandom);
                    rv_left = int'($urandom_range(1, 3));
                end
                rv_hi = !rv_hi;
            end
            if ($urandom_range(0, 199) == 0) enable = !enable;
            reset = ($urandom_range(0, 599) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_sample_scheduler
`default_nettype wire

// File: doc/sample_scheduler.md
Name: sample_scheduler

Overview:
- Sequences the DSP engine once per received audio frame.
- Detects a new frame from the I2S receiver's level-type rx_valid and latches the input sample.
- Issues a single-cycle tick to the engine, waits for the engine to finish, then registers the result for the I2S transmitter.
- Also handles: startup/enable muting, overrun detection/counting and an engine watchdog. Sits between i2s_trx and dsp_engine_seq in top; replaces the ad-hoc tick logic there.

Parameters:
- data_width, 16, sample width in bits
- mute_samples, 64, number of completed frames forced to 0 after reset or enable rise
- timeout_cycles, 2048, max sys_clk cycles in BUSY before watchdog abort
- count_width, 16, width of the saturating overrun/timeout counters

Ports:
- sys_clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  1 = schedule frames; 0 = ignore new frames
- rx_valid  in  1  level from i2s_trx, high for >=1 cycle per frame
- rx_sample  in  data_width  received sample, stable while rx_valid high
- engine_ready  in  1  engine idle/done
- engine_out  in  data_width  engine result, valid while engine_ready high
- tick  out  1  one-cycle start pulse to engine
- engine_in  out  data_width  latched sample fed to engine
- tx_sample  out  data_width  registered output sample to i2s_trx
- frame_done  out  1  one-cycle pulse when tx_sample updates
- overrun  out  1  one-cycle pulse on dropped frame
- overrun_count  out  count_width  saturating count of dropped frames
- timeout_count  out  count_width  saturating count of watchdog aborts
- state  out  2  current FSM state, for LEDs/debug

Behaviour:
- Reset values:
  - tick, frame_done, overrun = 0
  - engine_in, tx_sample = 0
  - overrun_count, timeout_count = 0
  - state = IDLE
  - rx_valid_q = 0
  - mute counter = mute_samples
  - watchdog = 0
- Frame edge:
  - new_frame = rx_valid & ~rx_valid_q; rx_valid_q is registered every cycle.
  - A level held high produces exactly one edge.
- FSM states (encoding in package): IDLE=0, ARM=1, BUSY=2. Encoding 3 is illegal and maps to IDLE.
- IDLE:
  - new_frame & enable: engine_in <= rx_sample, tick <= 1, state <= ARM.
  - new_frame & ~enable: ignored; no overrun.
- ARM:
  - tick is high for exactly this one cycle.
  - engine_ready is not sampled, because the engine drops ready on the cycle after tick.
  - Watchdog cleared; state <= BUSY.
- BUSY:
  - Watchdog increments each cycle.
  - engine_ready=1:
    - tx_sample <= (mute counter != 0) ? 0 : engine_out
    - frame_done <= 1
    - mute counter decrements if nonzero
    - state <= IDLE
  - Else if watchdog == timeout_cycles-1:
    - timeout_count += 1 (saturating)
    - tx_sample held, no frame_done
    - state <= IDLE
- Latency:
  - tick is visible 1 cycle after the cycle in which the edge is sampled.
  - tx_sample updates 1 cycle after engine_ready is seen in BUSY.
- Overrun:
  - new_frame in ARM or BUSY: overrun <= 1 for one cycle, overrun_count += 1 (saturating at all-ones), frame dropped, engine_in unchanged.
  - This includes the BUSY completion cycle: an edge that coincides with engine_ready is dropped.
- Enable:
  - Falling enable mid-frame does not abort; the current frame completes normally.
  - While enable=0 the mute counter reloads to mute_samples every cycle.
  - Output resumes only after mute_samples frames following the enable rise.
- Mute: mute_samples=0 disables muting.
- Reset mid-operation: returns immediately to reset values, and tick is low the following cycle.
- Simultaneous edges: the overrun and timeout counters saturate independently.

Decomposition:
- Package sample_sched_pkg:
  - state localparams IDLE/ARM/BUSY
  - state width (2)
  - counter saturation helper constant (all-ones of count_width)
- One natural sub-module, sat_counter (parameterised width, inc input, synchronous reset), instantiated twice for overrun_count and timeout_count.

Test Plan:
- Basic frame (mute_samples=0): rx_valid high 3 cycles with rx_sample=0x1234; engine_ready drops after tick and rises after 10 cycles with engine_out=0x0ABC -> exactly one tick, engine_in=0x1234, tx_sample=0x0ABC one cycle after ready, one frame_done.
- Mute: mute_samples=2, three frames each returning 0x7FFF -> tx_sample 0, 0, 0x7FFF.
- Overrun: second rx_valid edge while BUSY -> overrun pulse, overrun_count=1, no second tick, engine_in unchanged.
- Completion-cycle collision: edge in the same cycle engine_ready is seen -> frame completes, overrun_count increments, state IDLE.
- Watchdog: timeout_cycles=16, engine_ready held low -> return to IDLE after 16 BUSY cycles, timeout_count=1, tx_sample unchanged, no frame_done; next frame processes normally.
- Reset/enable: reset asserted in BUSY -> all outputs 0 and state IDLE next cycle. enable=0 with 5 rx_valid edges -> no ticks, no overruns.
